// File: rtl/popcount_pkg.sv
// ============================================================================
// Module      : popcount_pkg
// Description : Shared widths, types and byte popcount helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package popcount_pkg;

    localparam int BOARD_W = 64;
    localparam int CNT_W   = 7;
    localparam int PART_W  = 4;
    localparam int NPART   = BOARD_W / 8;

    typedef logic [BOARD_W-1:0] board_t;
    typedef logic [CNT_W-1:0]   count_t;

    function automatic logic [PART_W-1:0] popcnt8(input logic [7:0] b);
        logic [PART_W-1:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, b[i]};
        end
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter; the pointer moves only on a completed
//               handshake so a stalled grant keeps its turn.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IDW = $clog2(N);

    logic [IDW-1:0] r_last;
    logic [IDW-1:0] w_pos;
    logic           w_found;

    // Search starts one past the last winner and wraps.
    always_comb begin
        grant     = '0;
        grant_idx = r_last;
        w_found   = 1'b0;
        w_pos     = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = IDW'((int'(r_last) + k) % N);
            if (!w_found && req[w_pos]) begin
                w_found      = 1'b1;
                grant[w_pos] = 1'b1;
                grant_idx    = w_pos;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= IDW'(N - 1);
        end else if (advance) begin
            r_last <= grant_idx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/popcount_arbiter.sv
// ============================================================================
// Module      : popcount_arbiter
// Description : NREQ requesters share a two-stage 64-bit popcount pipeline
//               with one-hot tagged responses and per-requester backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcount_arbiter
    import popcount_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*BOARD_W-1:0] req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         resp_valid,
    output count_t                  resp_count,
    input  logic [NREQ-1:0]         resp_ready,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]                w_grant;
    logic [IDW-1:0]                 w_grant_idx;
    board_t                         w_operand;
    logic [NPART-1:0][PART_W-1:0]   w_part;
    count_t                         w_sum;
    logic                           w_s2_leave;
    logic                           w_s1_adv;
    logic                           w_accept;
    logic                           w_take;

    logic                           r_s1_v;
    logic [NPART-1:0][PART_W-1:0]   r_s1_part;
    logic [IDW-1:0]                 r_s1_idx;
    logic                           r_s2_v;
    count_t                         r_s2_cnt;
    logic [IDW-1:0]                 r_s2_idx;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (w_take),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_s2_leave = r_s2_v && resp_ready[r_s2_idx];
    assign w_s1_adv   = r_s1_v && (!r_s2_v || w_s2_leave);
    // Held off during reset so a requester never sees an acceptance that is discarded.
    assign w_accept   = (!r_s1_v || w_s1_adv) && !rst;
    assign w_take     = w_accept && (|req_valid);
    assign req_ready  = w_grant & {NREQ{w_accept}};

    always_comb begin
        w_operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_operand = req_data[i*BOARD_W +: BOARD_W];
            end
        end
    end

    always_comb begin
        w_part = '0;
        for (int p = 0; p < NPART; p++) begin
            w_part[p] = popcnt8(w_operand[p*8 +: 8]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int p = 0; p < NPART; p++) begin
            w_sum = w_sum + count_t'(r_s1_part[p]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
        end else begin
            if (w_take) begin
                r_s1_v <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_v <= 1'b0;
            end
            if (w_s1_adv) begin
                r_s2_v <= 1'b1;
            end else if (w_s2_leave) begin
                r_s2_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_s1_part <= w_part;
            r_s1_idx  <= w_grant_idx;
        end
        if (w_s1_adv) begin
            r_s2_cnt <= w_sum;
            r_s2_idx <= r_s1_idx;
        end
    end

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_resp
            assign resp_valid[i] = r_s2_v && (r_s2_idx == IDW'(i));
        end
    endgenerate

    assign resp_count = r_s2_cnt;
    assign busy       = r_s1_v | r_s2_v;

endmodule

`default_nettype wire

// File: tb/tb_popcount_arbiter.sv
// ============================================================================
// Module      : tb_popcount_arbiter
// Description : Self-checking bench; queue-based reference model of the
//               arbiter and two-deep result pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_popcount_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N*64-1:0]  req_data;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     resp_valid;
    logic [6:0]       resp_count;
    logic [N-1:0]     resp_ready;
    logic             busy;

    popcount_arbiter #(.NREQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_count (resp_count),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: in-flight ops in acceptance order; age = edges seen since acceptance.
    typedef struct {int idx; int cnt; int age;} op_t;
    op_t q[$];
    int  ptr;

    logic [N-1:0] obs_ready, obs_rv;
    logic [6:0]   obs_cnt;
    logic         obs_busy;

    typedef struct {logic [63:0] data; int idx; int exp;} vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ptr = N - 1;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic step();
        logic head, leave, acc, has_g;
        int g;
        logic [N-1:0] er, erv;
        #1;
        head = (q.size() > 0) && (q[0].age >= 2);
        erv = '0;
        if (head) erv[q[0].idx] = 1'b1;
        leave = head && resp_ready[q[0].idx];
        acc = (q.size() < 2) || leave;
        has_g = 1'b0;
        g = 0;
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (ptr + k) % N;
            if (!has_g && req_valid[p]) begin
                has_g = 1'b1;
                g = p;
            end
        end
        er = '0;
        if (has_g && acc) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("resp_valid", resp_valid, erv);
        if (head) chk("resp_count", resp_count, q[0].cnt);
        chk("busy", busy, q.size() > 0);
        obs_ready = req_ready;
        obs_rv    = resp_valid;
        obs_cnt   = resp_count;
        obs_busy  = busy;
        @(posedge clk);
        if (leave) void'(q.pop_front());
        foreach (q[i]) q[i].age++;
        if (has_g && acc) begin
            q.push_back('{g, $countones(req_data[64*g +: 64]), 1});
            ptr = g;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] bb[4];
        int          bexp[4];
        int          got[$];
        int          gotc[$];
        int          cnt[N];
        int          prev, first, k;
        logic [N-1:0] pend, oh;

        vt[0] = '{64'h0000_0000_0000_00FF, 2, 8};
        vt[1] = '{64'h0000_0000_0000_0000, 1, 0};
        vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 3, 64};
        vt[3] = '{64'h8000_0000_0000_0001, 0, 2};
        vt[4] = '{64'hAAAA_AAAA_AAAA_AAAA, 2, 32};
        vt[5] = '{64'h0123_4567_89AB_CDEF, 1, 32};

        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        resp_ready = '1;
        model_reset();

        // Reset state, with all requests pending.
        @(negedge clk);
        req_valid = '1;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b0;
        model_reset();

        // Single-operand vectors, including count boundaries.
        for (int v = 0; v < 6; v++) begin
            oh = '0;
            oh[vt[v].idx] = 1'b1;
            req_valid = oh;
            req_data = '0;
            req_data[64*vt[v].idx +: 64] = vt[v].data;
            step();
            chk("tbl_ready", obs_ready, oh);
            req_valid = '0;
            step();
            step();
            chk("tbl_resp_valid", obs_rv, oh);
            chk("tbl_count", obs_cnt, vt[v].exp);
            step();
            chk("tbl_busy_after", obs_busy, 0);
        end

        // Back-to-back from requester 0.
        bb[0] = 64'h0; bb[1] = 64'h1; bb[2] = 64'hFF; bb[3] = '1;
        bexp[0] = 0; bexp[1] = 1; bexp[2] = 8; bexp[3] = 64;
        for (int c = 0; c < 8; c++) begin
            req_valid = (c < 4) ? 4'b0001 : 4'b0000;
            req_data[63:0] = bb[c % 4];
            step();
            if (obs_rv[0]) begin
                got.push_back(int'(obs_cnt));
                gotc.push_back(c);
            end
        end
        chk("b2b_num", got.size(), 4);
        for (int j = 0; j < 4 && j < got.size(); j++) begin
            chk("b2b_count", got[j], bexp[j]);
            chk("b2b_cycle", gotc[j], j + 2);
        end

        // Fairness with all requesters continuously valid.
        req_valid = '1;
        resp_ready = '1;
        prev = -1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 100; c++) begin
            int g;
            for (int i = 0; i < N; i++) req_data[64*i +: 64] = {$urandom, $urandom};
            step();
            g = -1;
            for (int i = 0; i < N; i++) if (obs_ready[i]) g = i;
            if (g < 0) begin
                chk("rr_accept", 0, 1);
            end else begin
                if (prev >= 0) chk("rr_order", g, (prev + 1) % N);
                prev = g;
                cnt[g]++;
            end
        end
        for (int i = 0; i < N; i++) chk("rr_share", cnt[i], 25);
        req_valid = '0;
        repeat (3) step();

        // Pointer hold while stalled: req 0 fills both stages.
        resp_ready = '0;
        req_valid = 4'b0001;
        req_data[63:0] = 64'hF0F0;
        step();
        step();
        req_valid = 4'b0010;
        repeat (3) begin
            step();
            chk("hold_ready", obs_ready, 0);
        end
        resp_ready = '1;
        req_valid = 4'b1010;
        first = -1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (first < 0 && obs_ready != 0) first = int'(obs_ready);
            req_valid = req_valid & ~obs_ready;
        end
        chk("hold_first_grant", first, 4'b0010);
        req_valid = '0;
        repeat (3) step();

        // Backpressure on requester 0 with counts 1,2,3.
        bb[0] = 64'h1; bb[1] = 64'h3; bb[2] = 64'h7;
        got.delete();
        k = 0;
        for (int c = 0; c < 13; c++) begin
            resp_ready = (c < 7) ? 4'b1110 : 4'b1111;
            req_valid = (k < 3) ? 4'b0001 : 4'b0000;
            req_data[63:0] = bb[k % 3];
            step();
            if (obs_ready[0]) k++;
            if (c >= 2 && c < 7) begin
                chk("bp_ready_low", obs_ready, 0);
                chk("bp_count_stable", obs_cnt, 1);
            end
            if (obs_rv[0] && resp_ready[0]) got.push_back(int'(obs_cnt));
        end
        chk("bp_num", got.size(), 3);
        for (int j = 0; j < 3 && j < got.size(); j++) chk("bp_order", got[j], j + 1);

        // Asynchronous reset with both stages full.
        resp_ready = '0;
        req_valid = 4'b0001;
        req_data[63:0] = 64'hFFFF;
        step();
        step();
        req_valid = '0;
        step();
        #2;
        rst = 1'b1;
        req_valid = '1;
        #1;
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_req_ready", req_ready, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        resp_ready = '1;
        req_valid = '0;
        step();
        chk("arst_no_stale", obs_rv, 0);
        step();
        chk("arst_no_stale", obs_rv, 0);
        req_valid = '1;
        step();
        chk("arst_first_grant", obs_ready, 4'b0001);
        req_valid = '0;
        repeat (3) step();

        // Randomized traffic against the model.
        pend = '0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    case ($urandom_range(0, 5))
                        0:       req_data[64*i +: 64] = '0;
                        1:       req_data[64*i +: 64] = '1;
                        default: req_data[64*i +: 64] = {$urandom, $urandom};
                    endcase
                end
                resp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            req_valid = pend;
            step();
            pend = pend & ~(obs_ready & req_valid);
        end
        req_valid = '0;
        resp_ready = '1;
        repeat (4) step();
        chk("final_idle", obs_busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
